// File: rtl/alu_iter_pkg.sv
// Decoded ALU operator encoding shared between the decoder and the execute stage.
package alu_iter_pkg;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
      ALU_CLMUL, ALU_CLMULH, ALU_CLMULR,
      ALU_CPOP, ALU_CLZ, ALU_CTZ
   } alu_op_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Bit-serial CLMUL/CPOP/CLZ/CTZ: 32/BITS_PER_CYCLE+1 cycles, ready_o low until the result is taken.
// Define ALU_ITER_EARLY_EXIT_EN to leave BUSY once the remaining operand bits cannot change the result.
module alu_iter_unit
   import alu_iter_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 4,
   parameter bit RV32B          = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  alu_op_e     alu_operator_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        kill_i,
   output logic        result_valid_o,
   input  logic        result_ready_i,
   output logic [31:0] result_o,
   output logic        illegal_o
);

   localparam int ITERS = 32 / BITS_PER_CYCLE;
   localparam int CW    = $clog2(ITERS) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e          state_q, state_d;
   alu_op_e         op_q;
   logic [31:0]     a_q, b_q, a_in, final_res, result_q;
   logic [63:0]     acc_q, acc_d;
   logic            found_q, found_d, illegal_q;
   logic [CW-1:0]   cnt_q;
   logic [5:0]      idx;
   logic            supported, last_iter, early_exit, finish;

   assign supported = RV32B && (alu_operator_i inside
      {ALU_CLMUL, ALU_CLMULH, ALU_CLMULR, ALU_CPOP, ALU_CLZ, ALU_CTZ});

   // CLZ latches A bit-reversed so it shares the ascending CTZ scan.
   always_comb begin
      a_in = op_a_i;
      if (alu_operator_i == ALU_CLZ) begin
         for (int k = 0; k < 32; k++) a_in[k] = op_a_i[31-k];
      end
   end

   always_comb begin
      acc_d   = acc_q;
      found_d = found_q;
      idx     = '0;
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
         idx = 6'(int'(cnt_q) * BITS_PER_CYCLE + j);
         case (op_q)
            ALU_CLMUL, ALU_CLMULH, ALU_CLMULR: begin
               if (b_q[idx[4:0]]) acc_d = acc_d ^ ({32'b0, a_q} << idx);
            end
            ALU_CPOP: acc_d = acc_d + 64'(a_q[idx[4:0]]);
            default: begin
               if (!found_d && a_q[idx[4:0]]) begin
                  acc_d   = 64'(idx);
                  found_d = 1'b1;
               end
            end
         endcase
      end
   end

   assign last_iter = (cnt_q == CW'(ITERS - 1));

`ifdef ALU_ITER_EARLY_EXIT_EN
   logic [31:0] rem_mask;
   always_comb begin
      rem_mask = 32'hFFFF_FFFF << 7'((int'(cnt_q) + 1) * BITS_PER_CYCLE);
      case (op_q)
         ALU_CLMUL, ALU_CLMULH, ALU_CLMULR: early_exit = ((b_q & rem_mask) == '0);
         ALU_CPOP:                          early_exit = ((a_q & rem_mask) == '0);
         default:                           early_exit = found_d;
      endcase
   end
`else
   assign early_exit = 1'b0;
`endif

   assign finish = last_iter || early_exit;

   always_comb begin
      case (op_q)
         ALU_CLMUL:  final_res = acc_d[31:0];
         ALU_CLMULH: final_res = acc_d[63:32];
         ALU_CLMULR: final_res = acc_d[62:31];
         ALU_CPOP:   final_res = acc_d[31:0];
         default:    final_res = found_d ? acc_d[31:0] : 32'd32;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      ready_o        = 1'b0;
      result_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) state_d = supported ? BUSY : DONE;
         end
         BUSY: if (finish) state_d = DONE;
         DONE: begin
            result_valid_o = 1'b1;
            if (result_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (kill_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q      <= ALU_ADD;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         found_q   <= 1'b0;
         cnt_q     <= '0;
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else if (!kill_i) begin
         if (state_q == IDLE && valid_i) begin
            if (supported) begin
               op_q      <= alu_operator_i;
               a_q       <= a_in;
               b_q       <= op_b_i;
               acc_q     <= '0;
               found_q   <= 1'b0;
               cnt_q     <= '0;
               illegal_q <= 1'b0;
            end else begin
               result_q  <= '0;
               illegal_q <= 1'b1;
            end
         end else if (state_q == BUSY) begin
            acc_q   <= acc_d;
            found_q <= found_d;
            cnt_q   <= cnt_q + CW'(1);
            if (finish) result_q <= final_res;
         end
      end
   end

   assign result_o  = result_q;
   assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_iter_unit.sv
// Scoreboard bench for alu_iter_unit with BITS_PER_CYCLE=4.
module tb_alu_iter_unit;
   import alu_iter_pkg::*;

   localparam int BPC   = 4;
   localparam int ITERS = 32 / BPC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        ready;
   alu_op_e     op = ALU_ADD;
   logic [31:0] a = '0, b = '0;
   logic        kill = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] result;
   logic        illegal;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] res;
      logic        ill;
      int          lat;
   } exp_t;
   exp_t sb[$];

   alu_iter_unit #(.BITS_PER_CYCLE(BPC), .RV32B(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
      .alu_operator_i(op), .op_a_i(a), .op_b_i(b), .kill_i(kill),
      .result_valid_o(res_valid), .result_ready_i(res_ready),
      .result_o(result), .illegal_o(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] clmul64(input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p = '0;
      for (int i = 0; i < 32; i++) if (y[i]) p ^= ({32'b0, x} << i);
      return p;
   endfunction

   function automatic exp_t model(input alu_op_e o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      logic [63:0] p;
      logic [31:0] cnt;
      logic [63:0] rest;
      e.res = '0; e.ill = 1'b0; e.lat = ITERS + 1;
      p = clmul64(x, y);
      case (o)
         ALU_CLMUL:  e.res = p[31:0];
         ALU_CLMULH: e.res = p[63:32];
         ALU_CLMULR: e.res = p[62:31];
         ALU_CPOP: begin
            cnt = 0;
            for (int i = 0; i < 32; i++) cnt += 32'(x[i]);
            e.res = cnt;
         end
         ALU_CTZ: begin
            e.res = 32;
            for (int i = 31; i >= 0; i--) if (x[i]) e.res = i;
         end
         ALU_CLZ: begin
            e.res = 32;
            for (int i = 0; i < 32; i++) if (x[i]) e.res = 31 - i;
         end
         default: begin e.ill = 1'b1; e.lat = 1; end
      endcase
`ifdef ALU_ITER_EARLY_EXIT_EN
      if (!e.ill) begin
         for (int k = ITERS - 1; k >= 0; k--) begin
            case (o)
               ALU_CLMUL, ALU_CLMULH, ALU_CLMULR: rest = {32'b0, y} >> ((k + 1) * BPC);
               ALU_CPOP: rest = {32'b0, x} >> ((k + 1) * BPC);
               default: rest = (e.res < 32 && e.res < (k + 1) * BPC) ? 64'd0 : 64'd1;
            endcase
            if (rest == 0) e.lat = k + 2;
         end
      end
`endif
      return e;
   endfunction

   task automatic run_op(input alu_op_e o, input logic [31:0] x, input logic [31:0] y, input int hold);
      exp_t e;
      int lat;
      sb.push_back(model(o, x, y));
      @(negedge clk);
      valid = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      valid = 1'b0; a = $urandom; b = $urandom;
      lat = 1;
      while (!res_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      check($sformatf("%s_lat", o.name()), 64'(lat), 64'(e.lat));
      check($sformatf("%s_res", o.name()), 64'(result), 64'(e.res));
      check($sformatf("%s_ill", o.name()), 64'(illegal), 64'(e.ill));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", 64'(res_valid), 64'd1);
         check("hold_res", 64'(result), 64'(e.res));
         check("hold_ill", 64'(illegal), 64'(e.ill));
         check("hold_ready", 64'(ready), 64'd0);
      end
      check("done_ready", 64'(ready), 64'd0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("idle_ready", 64'(ready), 64'd1);
      check("idle_valid", 64'(res_valid), 64'd0);
   endtask

   initial begin
      int seen;
      alu_op_e rops [6] = '{ALU_CLMUL, ALU_CLMULH, ALU_CLMULR, ALU_CPOP, ALU_CLZ, ALU_CTZ};

      repeat (3) @(negedge clk);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_illegal", 64'(illegal), 64'd0);
      rst = 1'b0;

      run_op(ALU_CLMUL, 32'h3, 32'h3, 0);
      run_op(ALU_CLMULH, 32'h8000_0000, 32'h2, 0);
      run_op(ALU_CLMULR, 32'h8000_0000, 32'h8000_0000, 0);
      run_op(ALU_CPOP, 32'hF0F0_F0F0, 32'h0, 0);
      run_op(ALU_CLZ, 32'h0, 32'h0, 0);
      run_op(ALU_CTZ, 32'h0000_0100, 32'h0, 0);
      run_op(ALU_CLZ, 32'h0001_0000, 32'h0, 0);
      run_op(ALU_CTZ, 32'h0, 32'h0, 0);
      run_op(ALU_CLMUL, 32'h1234_5678, 32'h1, 0);
      run_op(ALU_ADD, 32'h5, 32'h7, 5);

      // Kill in the third BUSY cycle of a CLMUL.
      @(negedge clk);
      valid = 1'b1; op = ALU_CLMUL; a = 32'hDEAD_BEEF; b = 32'hFFFF_FFFF;
      @(negedge clk);
      valid = 1'b0;
      repeat (2) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_ready", 64'(ready), 64'd1);
      check("kill_valid", 64'(res_valid), 64'd0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      check("kill_no_result", 64'(seen), 64'd0);
      run_op(ALU_CPOP, 32'hFF, 32'h0, 0);

      // Kill together with a request in IDLE drops the request.
      @(negedge clk);
      valid = 1'b1; kill = 1'b1; op = ALU_CPOP; a = 32'h7;
      @(negedge clk);
      valid = 1'b0; kill = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (res_valid || !ready) seen++;
      end
      check("kill_idle_drop", 64'(seen), 64'd0);

      // Reset while a result waits in DONE.
      @(negedge clk);
      valid = 1'b1; op = ALU_CLMUL; a = 32'h3; b = 32'h3;
      @(negedge clk);
      valid = 1'b0;
      seen = 0;
      while (!res_valid && seen < 100) begin
         @(negedge clk);
         seen++;
      end
      check("pre_rst_valid", 64'(res_valid), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_ready", 64'(ready), 64'd1);
      check("mid_rst_valid", 64'(res_valid), 64'd0);
      check("mid_rst_result", 64'(result), 64'd0);
      check("mid_rst_illegal", 64'(illegal), 64'd0);

      for (int t = 0; t < 12; t++)
         run_op(rops[t % 6], $urandom, $urandom, 0);
      run_op(ALU_CPOP, 32'h0, 32'h0, 0);
      run_op(ALU_CLMULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
